// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: buffered multi-channel I2C command engine between user registers and the sequencer port.
module i2c_cmd_queue #(
  parameter int FIFO_DEPTH     = 16,
  parameter int NUM_CHAN       = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int SETTLE_CYCLES  = 16,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]               wdata,
  output logic                      wr_ack,
  input  logic                      rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0] raddr,
  output logic [31:0]               rdata,
  output logic                      rd_ack,
  output logic                      seq_req,
  output logic                      seq_op,
  output logic [7:0]                seq_dev_id,
  output logic [7:0]                seq_addr,
  output logic [7:0]                seq_wdata,
  input  logic                      seq_ack,
  input  logic [7:0]                seq_rdata,
  output logic [(NUM_CHAN > 1 ? $clog2(NUM_CHAN) : 1)-1:0] chan_sel,
  output logic                      busy,
  output logic                      irq
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = NUM_CHAN > 1 ? $clog2(NUM_CHAN) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES) + 1;
  localparam int CMW = 25 + CW;
  localparam int RMW = 9 + CW;
  typedef enum logic [1:0] {IDLE, SETTLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CMW-1:0] cmd_mem [FIFO_DEPTH];
  logic [RMW-1:0] rsp_mem [FIFO_DEPTH];
  logic [AW-1:0] cmd_wr_q, cmd_rd_q, rsp_wr_q, rsp_rd_q;
  logic [LW-1:0] cmd_lvl_q, rsp_lvl_q;
  logic [CW-1:0] chan_q;
  logic [31:0] rdata_q, rdata_d, status, rsp_word;
  logic [7:0] dev_q, addr_q, wd_q;
  logic seq_op_q, wr_ack_q, rd_ack_q, irq_q, en_q, irq_en_q, flush_q, flush_d;
  logic ovf_q, to_q, badch_q;
  logic wr_cmd, wr_stat, wr_ctrl, chan_ok, flush_go, cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic go, cmd_push, rsp_push, rsp_pop, ack_ok, tmo, unused_ok;
  logic [CMW-1:0] head;
  logic [RMW-1:0] rsp_head, rsp_din;
  assign unused_ok = ^{waddr[AXI_ADDR_WIDTH-1:8], raddr[AXI_ADDR_WIDTH-1:8], wdata[27:25]};
  assign wr_cmd    = wr_en && waddr[7:0] == 8'h00;
  assign wr_stat   = wr_en && waddr[7:0] == 8'h08;
  assign wr_ctrl   = wr_en && waddr[7:0] == 8'h0C;
  assign chan_ok   = {28'd0, wdata[31:28]} < 32'(NUM_CHAN);
  assign cmd_full  = cmd_lvl_q == LW'(FIFO_DEPTH);
  assign cmd_empty = cmd_lvl_q == '0;
  assign rsp_full  = rsp_lvl_q == LW'(FIFO_DEPTH);
  assign rsp_empty = rsp_lvl_q == '0;
  assign head      = cmd_mem[cmd_rd_q];
  assign rsp_head  = rsp_mem[rsp_rd_q];
  assign flush_go  = flush_q && state_q == IDLE;
  assign flush_d   = (wr_ctrl & wdata[1]) | (flush_q & (state_q != IDLE));
  // a read may only leave IDLE when its response is guaranteed a slot
  assign go        = state_q == IDLE && en_q && !cmd_empty && !flush_q && (!head[24] || !rsp_full);
  assign cmd_push  = wr_cmd && chan_ok && (!cmd_full || go) && !flush_go;
  assign ack_ok    = state_q == WAIT && seq_ack;
  assign tmo       = state_q == WAIT && !seq_ack && cnt_q == TW'(TIMEOUT_CYCLES - 2);
  assign rsp_push  = seq_op_q && (ack_ok || tmo);
  assign rsp_pop   = rd_en && raddr[7:0] == 8'h04 && !rsp_empty;
  assign rsp_din   = {tmo, chan_q, tmo ? 8'hFF : seq_rdata};
  assign rsp_word  = rsp_empty ? 32'd0 : {14'd0, rsp_head[RMW-1], 1'b1, 4'd0, 4'(rsp_head[8 +: CW]), rsp_head[7:0]};
  assign status    = {8'd0, 8'(rsp_lvl_q), 8'(cmd_lvl_q), 1'b0, badch_q, to_q, ovf_q, rsp_empty, cmd_empty, cmd_full, busy};
  assign rdata_d   = raddr[7:0] == 8'h04 ? rsp_word :
                     raddr[7:0] == 8'h08 ? status :
                     raddr[7:0] == 8'h0C ? {29'd0, irq_en_q, flush_q, en_q} : 32'd0;
  assign seq_req    = state_q == ISSUE;
  assign busy       = state_q != IDLE;
  assign seq_op     = seq_op_q;
  assign seq_dev_id = dev_q;
  assign seq_addr   = addr_q;
  assign seq_wdata  = wd_q;
  assign chan_sel   = chan_q;
  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;
  assign rdata      = rdata_q;
  assign irq        = irq_q;
  // the timer counts from the ISSUE cycle, so ISSUE plus WAIT spans TIMEOUT_CYCLES cycles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = head[25 +: CW] != chan_q ? SETTLE : ISSUE;
        cnt_d = '0;
      end
      SETTLE: begin
        cnt_d = cnt_q + TW'(1);
        state_d = cnt_q == TW'(SETTLE_CYCLES - 1) ? ISSUE : SETTLE;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      default: begin
        cnt_d = cnt_q + TW'(1);
        state_d = (ack_ok || tmo) ? IDLE : WAIT;
      end
    endcase
  end
  always_ff @(posedge s_axi_aclk) begin
    if (cmd_push) cmd_mem[cmd_wr_q] <= {wdata[28 +: CW], wdata[24:0]};
    if (rsp_push) rsp_mem[rsp_wr_q] <= rsp_din;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      {cmd_wr_q, cmd_rd_q, rsp_wr_q, rsp_rd_q} <= '0;
      {cmd_lvl_q, rsp_lvl_q} <= '0;
      {wr_ack_q, rd_ack_q, rdata_q, irq_q} <= '0;
      {en_q, irq_en_q, flush_q, ovf_q, to_q, badch_q} <= '0;
      {seq_op_q, dev_q, addr_q, wd_q, chan_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_ack_q <= wr_en;
      rd_ack_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
      if (wr_ctrl) {irq_en_q, en_q} <= {wdata[2], wdata[0]};
      flush_q <= flush_d;
      ovf_q <= (ovf_q & ~(wr_stat & wdata[4])) | (wr_cmd & chan_ok & cmd_full & ~go);
      to_q <= (to_q & ~(wr_stat & wdata[5])) | tmo;
      badch_q <= (badch_q & ~(wr_stat & wdata[6])) | (wr_cmd & ~chan_ok);
      irq_q <= irq_en_q & (~rsp_empty | ovf_q | to_q | badch_q);
      if (go) {chan_q, seq_op_q, dev_q, addr_q, wd_q} <= head;
      if (flush_go) begin
        {cmd_wr_q, cmd_rd_q, rsp_wr_q, rsp_rd_q} <= '0;
        {cmd_lvl_q, rsp_lvl_q} <= '0;
      end else begin
        cmd_wr_q <= cmd_wr_q + AW'(cmd_push);
        cmd_rd_q <= cmd_rd_q + AW'(go);
        cmd_lvl_q <= cmd_lvl_q + LW'(cmd_push) - LW'(go);
        rsp_wr_q <= rsp_wr_q + AW'(rsp_push);
        rsp_rd_q <= rsp_rd_q + AW'(rsp_pop);
        rsp_lvl_q <= rsp_lvl_q + LW'(rsp_push) - LW'(rsp_pop);
      end
    end
  end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// tb_i2c_cmd_queue: directed plus randomized checks of i2c_cmd_queue against a queue-based reference model.
module tb_i2c_cmd_queue;
  localparam int DEPTH = 4, NCH = 4, TO = 20, ST = 3;
  logic clk = 1'b0, rst_n = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0, seq_ack = 1'b0;
  logic [31:0] waddr = '0, raddr = '0, wdata = '0;
  logic [7:0] seq_rdata = '0;
  logic wr_ack, rd_ack, seq_req, seq_op, busy, irq;
  logic [31:0] rdata;
  logic [7:0] seq_dev_id, seq_addr, seq_wdata;
  logic [1:0] chan_sel;
  int vectors = 0, miscompares = 0;
  logic [3:0] cur = '0;
  logic [31:0] mrsp [$];
  bit mbad = 1'b0;
  always #5 clk = ~clk;
  i2c_cmd_queue #(.FIFO_DEPTH(DEPTH), .NUM_CHAN(NCH), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .AXI_ADDR_WIDTH(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wr_ack(wr_ack),
    .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .rd_ack(rd_ack), .seq_req(seq_req), .seq_op(seq_op),
    .seq_dev_id(seq_dev_id), .seq_addr(seq_addr), .seq_wdata(seq_wdata), .seq_ack(seq_ack),
    .seq_rdata(seq_rdata), .chan_sel(chan_sel), .busy(busy), .irq(irq));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; waddr = {24'd0, a}; wdata = d;
    tick();
    chk("wr_ack", {31'd0, wr_ack}, 32'd1);
    wr_en = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    rd_en = 1'b1; raddr = {24'd0, a};
    tick();
    chk("rd_ack", {31'd0, rd_ack}, 32'd1);
    v = rdata;
    rd_en = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, e);
  endtask
  task automatic rsp_chk(input string tag);
    logic [31:0] e;
    e = mrsp.size() != 0 ? mrsp.pop_front() : 32'd0;
    rd_chk(tag, 8'h04, e);
  endtask
  task automatic no_req(input string tag, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin tick(); seen |= seq_req; end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask
  // Queue one command, expect its request after the modelled latency, optionally acknowledge it d cycles later.
  task automatic send(input logic [31:0] c, input int d, input logic [7:0] r, input bit ack);
    int n = 0;
    wr(8'h00, c);
    chk("req_early", {31'd0, seq_req}, 32'd0);
    while (!seq_req && n < 100) begin tick(); n++; end
    chk("latency", n, c[31:28] != cur ? ST + 1 : 1);
    chk("fields", {5'd0, seq_op, seq_dev_id, seq_addr, seq_wdata, chan_sel}, {5'd0, c[24:0], c[29:28]});
    cur = c[31:28];
    if (ack) begin
      tick();
      chk("req_pulse", {31'd0, seq_req}, 32'd0);
      repeat (d - 1) tick();
      seq_ack = 1'b1; seq_rdata = r;
      tick();
      seq_ack = 1'b0;
      if (c[24]) mrsp.push_back({14'd0, 1'b0, 1'b1, 4'd0, c[31:28], r});
    end
  endtask
  initial begin
    int n;
    logic [31:0] c;
    #2 rst_n = 1'b0;
    tick();
    chk("rst_out", {23'd0, seq_req, busy, irq, wr_ack, rd_ack, seq_op, chan_sel, 1'b0}, 32'd0);
    chk("rst_seq", {8'd0, seq_dev_id, seq_addr, seq_wdata}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    rd_chk("rst_status", 8'h08, 32'h0000_000C);
    rd_chk("rst_ctrl", 8'h0C, 32'd0);
    wr(8'h0C, 32'h1);
    rd_chk("ctrl_en", 8'h0C, 32'h1);
    send(32'h0050_1234, 1, 8'h00, 1'b1);
    chk("wr_idle", {31'd0, busy}, 32'd0);
    rd_chk("wr_no_rsp", 8'h08, 32'h0000_000C);
    send(32'h2150_0700, 2, 8'hA5, 1'b1);
    rsp_chk("rsp_read");
    rd_chk("rsp_empty", 8'h04, 32'd0);
    wr(8'h0C, 32'h0);
    for (int i = 0; i <= DEPTH; i++) wr(8'h00, 32'h0000_0100 | i);
    rd_chk("ovf_status", 8'h08, (DEPTH << 8) | 32'h1A);
    wr(8'h08, 32'h10);
    rd_chk("ovf_w1c", 8'h08, (DEPTH << 8) | 32'h0A);
    wr(8'h0C, 32'h2);
    tick();
    rd_chk("flush_idle", 8'h08, 32'h0000_000C);
    rd_chk("flush_clr", 8'h0C, 32'h0);
    wr(8'h0C, 32'h5);
    send(32'h1160_0300, 0, 8'h00, 1'b0);
    repeat (TO - 1) tick();
    chk("to_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("to_done", {31'd0, busy}, 32'd0);
    rd_chk("to_status", 8'h08, 32'h0001_0024);
    chk("to_irq", {31'd0, irq}, 32'd1);
    mrsp.push_back(32'h0003_01FF);
    rsp_chk("to_rsp");
    wr(8'h08, 32'h20);
    rd_chk("to_w1c", 8'h08, 32'h0000_000C);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    send(32'h1160_0301, TO - 1, 8'h3C, 1'b1);
    rd_chk("ack_wins", 8'h08, 32'h0001_0004);
    rsp_chk("ack_wins_rsp");
    wr(8'h0C, 32'h1);
    for (int i = 0; i < DEPTH; i++) send(32'h1100_0000 | i, 1, 8'(8'h40 + i), 1'b1);
    wr(8'h00, 32'h1100_0010);
    no_req("bp_stall", 8);
    chk("bp_busy", {31'd0, busy}, 32'd0);
    rsp_chk("bp_pop");
    n = 0;
    while (!seq_req && n < 50) begin tick(); n++; end
    chk("bp_resume", n, 32'd1);
    tick();
    seq_ack = 1'b1; seq_rdata = 8'h77;
    tick();
    seq_ack = 1'b0;
    mrsp.push_back(32'h0001_0177);
    repeat (DEPTH) rsp_chk("bp_drain");
    rsp_chk("bp_empty");
    wr(8'h0C, 32'h5);
    wr(8'h00, 32'hF000_0000);
    no_req("badch_drop", 4);
    rd_chk("badch_status", 8'h08, 32'h0000_004C);
    chk("badch_irq", {31'd0, irq}, 32'd1);
    wr(8'h08, 32'h40);
    rd_chk("badch_w1c", 8'h08, 32'h0000_000C);
    wr(8'h0C, 32'h1);
    send(32'h2170_0101, 0, 8'h00, 1'b0);
    wr(8'h00, 32'h2000_0002);
    wr(8'h00, 32'h2000_0003);
    wr(8'h0C, 32'h3);
    rd_chk("flush_pend", 8'h0C, 32'h3);
    rd_chk("flush_wait", 8'h08, 32'h0000_0209);
    seq_ack = 1'b1; seq_rdata = 8'h11;
    tick();
    seq_ack = 1'b0;
    no_req("flush_noreq", 6);
    rd_chk("flush_levels", 8'h08, 32'h0000_000C);
    rd_chk("flush_done", 8'h0C, 32'h1);
    send(32'h1000_0055, 0, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("rst_issue", {30'd0, seq_req, busy}, 32'd0);
    tick();
    rst_n = 1'b1; cur = '0; mrsp.delete();
    wr(8'h0C, 32'h1);
    send(32'h0000_0066, 0, 8'h00, 1'b0);
    tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_wait", {30'd0, seq_req, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    rd_chk("rst2_status", 8'h08, 32'h0000_000C);
    rd_chk("rst2_ctrl", 8'h0C, 32'h0);
    wr(8'h0C, 32'h1);
    for (int i = 0; i < 40; i++) begin
      c = $urandom;
      c[31:28] = $urandom_range(0, 7) == 0 ? 4'($urandom_range(NCH, 15)) : 4'($urandom_range(0, NCH - 1));
      if (c[31:28] >= NCH) begin
        wr(8'h00, c);
        mbad = 1'b1;
        no_req("rnd_bad", 3);
      end else begin
        if (c[24] && mrsp.size() == DEPTH) rsp_chk("rnd_full_pop");
        send(c, $urandom_range(1, 4), 8'($urandom), 1'b1);
        if ($urandom_range(0, 2) == 0) rsp_chk("rnd_rsp");
      end
    end
    while (mrsp.size() != 0) rsp_chk("rnd_drain");
    rsp_chk("rnd_empty");
    rd_chk("rnd_status", 8'h08, {25'd0, mbad, 6'b001100});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
